spart_receiver: RTL and testbench
=================================

SPART_RECEIVER -- requirements
Module: spart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving Enable ticks per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving payload bits per frame.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port RxD  in  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port Enable  in  1  one-clk pulse at OVERSAMPLE x baud, from the baud generator.
REQ-007 SHALL have port IOADDR  in  2  register address; 2'b00 = data register.
REQ-008 SHALL have port IORW  in  1  1 = read, 0 = write.
REQ-009 SHALL have port RX_DATA  out  DATA_BITS  last received byte, registered.
REQ-010 SHALL have port RDA  out  1  receive data available.
REQ-011 SHALL have port FE  out  1  framing error; stop bit sampled 0.
REQ-012 SHALL have port OVR  out  1  overrun; a byte was overwritten before being read.

Function
REQ-013 SHALL pass RxD through a 2-flop synchronizer (both flops reset to 1); all sampling uses the second flop, rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, with a 4-bit tick counter and a 3-bit bit index.
REQ-015 SHALL freeze FSM, counters and shift register in any cycle with Enable=0.
REQ-016 IDLE: on Enable with rx_s=0 -> START, tick counter=1; otherwise stay in IDLE.
REQ-017 START: on Enable, increment the tick counter; when it reaches OVERSAMPLE/2-1 (7), check rx_s.
  - rx_s=0: -> DATA, with counter=0 and bit index=0.
  - rx_s=1: false start; -> IDLE; no flags change.
REQ-018 DATA: on Enable, increment the tick counter; at count 15, shift rx_s into the shift register MSB (right shift, LSB-first line order), set counter=0, increment bit index; after bit index 7 -> STOP.
REQ-019 STOP: on Enable at count 15, sample the stop bit, then on the next clk edge:
  - load RX_DATA from the shift register;
  - set RDA=1;
  - set FE to the inverse of the stop sample;
  - -> IDLE.
  Next start detection is possible on the following Enable (mid-stop resync).
REQ-020 SHALL set OVR=1 on a load when RDA=1 and no read is in progress that cycle; RX_DATA is overwritten regardless.
REQ-021 A read is a cycle with IORW=1 and IOADDR=2'b00; it clears RDA, FE and OVR on the next edge.
REQ-022 Read and load in the same cycle: the load wins; RDA stays 1, OVR is not set, and FE takes the new frame's value.
REQ-023 Writes (IORW=0) and other IOADDR values SHALL have no effect on this block.
REQ-024 RX_DATA SHALL be stable between loads; a read does not alter it.
REQ-025 Latency: RDA rises exactly one clk after the Enable tick at stop-bit mid-sample.

Reset
REQ-026 rst=0 SHALL asynchronously force the following, aborting any frame in progress:
  - FSM=IDLE; counters=0; shift register=0;
  - RX_DATA=8'h00; RDA=0; FE=0; OVR=0;
  - synchronizer flops=1.
REQ-027 After rst deasserts, the first start SHALL be detected only on a falling rx_s with Enable=1.

Structure
REQ-028 A shared package SHALL hold:
  - the FSM state enum;
  - OVERSAMPLE and DATA_BITS defaults;
  - the derived MID_TICK constant;
  - the data-register address constant 2'b00.
REQ-029 The synchronizer SHALL be a separate sub-module, rx_sync (2-flop, reset value parameterized), reusable elsewhere in the SPART.

Verification
REQ-030 Bench SHALL use Enable every 4 clk (OVERSAMPLE=16) and cover these scenarios:
  - Frame 0xA5 with stop=1 -> RDA=1, RX_DATA=8'hA5, FE=0, OVR=0; a read cycle then gives RDA=0 next clk.
  - RxD low for 4 Enable ticks then high -> FSM returns to IDLE; RDA, FE, OVR stay 0.
  - Frame 0x3C with stop bit 0 -> RDA=1, RX_DATA=8'h3C, FE=1.
  - Frames 0x3C then 0xC3 with no read -> RX_DATA=8'hC3, OVR=1; a read clears RDA and OVR.
  - Read asserted in the same cycle as the load of 0x55 while RDA=1 -> RDA stays 1, OVR=0, RX_DATA=8'h55.
  - rst=0 during bit 4 of a frame, then frame 0x81 -> all outputs 0 during reset, then RX_DATA=8'h81 with no corruption.

Source files
------------

// File: rtl/spart_receiver_pkg.sv
// Shared SPART receive-side definitions: FSM states, frame-geometry defaults and register map.
package spart_receiver_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int MID_TICK       = OVERSAMPLE_DEF / 2 - 1;

  localparam logic [1:0] DATA_ADDR = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  function automatic int mid_tick_of(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/spart_receiver_rx_sync.sv
// Two-flop synchronizer for an asynchronous level; two clk latency, no flow control.
// Reset value is a parameter so idle-high and idle-low lines can share it.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spart_receiver.sv
// SPART receiver: oversampled UART RX with data/status register; RDA one clk after the stop-bit mid sample.
// No backpressure: an unread byte is overwritten and flagged by OVR.
module spart_receiver
  import spart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RxD,
  input  logic                 Enable,
  input  logic [1:0]           IOADDR,
  input  logic                 IORW,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RDA,
  output logic                 FE,
  output logic                 OVR
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID       = CNT_W'(mid_tick_of(OVERSAMPLE));
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_sync #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (RxD),
    .q_o   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 load;
  logic                 rd_hit;

  assign rd_hit = IORW && (IOADDR == DATA_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    ovr_d     = ovr_q;
    load      = 1'b0;

    if (Enable) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MID) begin
            // Line back high at mid start bit is a glitch, not a frame.
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_TICK) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_TICK) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A load beats a coincident read; that read still suppresses OVR.
    if (load) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      fe_d      = ~rx_s;
      ovr_d     = rd_hit ? 1'b0 : (ovr_q | rda_q);
    end else if (rd_hit) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign RX_DATA = rx_data_q;
  assign RDA     = rda_q;
  assign FE      = fe_q;
  assign OVR     = ovr_q;

endmodule

// File: tb/tb_spart_receiver.sv
// Directed bench for spart_receiver: frames driven on RxD, expected bytes/flags queued and checked on receipt.
module tb_spart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       RxD;
  logic       Enable;
  logic [1:0] IOADDR;
  logic       IORW;
  logic [7:0] RX_DATA;
  logic       RDA;
  logic       FE;
  logic       OVR;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_rise = -1;
  logic rda_prev = 1'b0;

  spart_receiver #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .RxD    (RxD),
    .Enable (Enable),
    .IOADDR (IOADDR),
    .IORW   (IORW),
    .RX_DATA(RX_DATA),
    .RDA    (RDA),
    .FE     (FE),
    .OVR    (OVR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Enable is high in every cycle whose number is a multiple of 4.
  initial begin
    Enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      Enable = (cyc % 4 == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (RDA === 1'b1 && !rda_prev) last_rise = cyc;
      rda_prev = (RDA === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic align();
    hold(1);
    while (cyc % 4 != 1) hold(1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    RxD = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      hold(BIT_CLKS);
    end
    if (stop) begin
      RxD = 1'b1;
      hold(BIT_CLKS);
    end else begin
      // Short low stop bit: covers the mid sample but cannot pass as a new start.
      RxD = 1'b0;
      hold(40);
      RxD = 1'b1;
      hold(BIT_CLKS - 40);
    end
  endtask

  task automatic check_frame(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (RDA !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rda"}, 32'(RDA), 32'd1);
    e = sb_q.pop_front();
    chk({tag, "_data"}, 32'(RX_DATA), 32'(e.data));
    chk({tag, "_fe"}, 32'(FE), 32'(e.fe));
    chk({tag, "_ovr"}, 32'(OVR), 32'(e.ovr));
  endtask

  task automatic io_read(input logic [1:0] addr);
    hold(1);
    IORW   = 1'b1;
    IOADDR = addr;
    hold(1);
    IORW   = 1'b0;
    IOADDR = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int s;
    int off;
    rst    = 1'b0;
    RxD    = 1'b1;
    IORW   = 1'b0;
    IOADDR = 2'b00;
    off    = 0;

    @(negedge clk);
    chk("reset_rx_data", 32'(RX_DATA), 32'h00);
    chk("reset_rda", 32'(RDA), 32'd0);
    chk("reset_fe", 32'(FE), 32'd0);
    chk("reset_ovr", 32'(OVR), 32'd0);
    hold(3);
    rst = 1'b1;
    hold(20);
    chk("idle_rda", 32'(RDA), 32'd0);

    // Clean frame; its timing also calibrates the load cycle for the collision test.
    align();
    s = cyc;
    sb_q.push_back('{data: 8'hA5, fe: 1'b0, ovr: 1'b0});
    send_frame(8'hA5, 1'b1);
    check_frame("a5");
    off = last_rise - s;
    chk("rda_one_clk_after_enable", 32'((last_rise - 1) % 4), 32'd0);
    io_read(2'b01);
    chk("other_addr_no_clear", 32'(RDA), 32'd1);
    io_read(2'b00);
    chk("a5_read_clears_rda", 32'(RDA), 32'd0);
    chk("a5_read_keeps_data", 32'(RX_DATA), 32'hA5);

    // Glitch: low for 4 Enable ticks only.
    align();
    RxD = 1'b0;
    hold(16);
    RxD = 1'b1;
    hold(800);
    chk("false_start_rda", 32'(RDA), 32'd0);
    chk("false_start_fe", 32'(FE), 32'd0);
    chk("false_start_ovr", 32'(OVR), 32'd0);
    chk("false_start_data", 32'(RX_DATA), 32'hA5);

    align();
    sb_q.push_back('{data: 8'h3C, fe: 1'b1, ovr: 1'b0});
    send_frame(8'h3C, 1'b0);
    check_frame("fe_3c");
    hold(100);
    chk("fe_no_spurious_ovr", 32'(OVR), 32'd0);
    io_read(2'b00);
    chk("fe_read_clears_rda", 32'(RDA), 32'd0);
    chk("fe_read_clears_fe", 32'(FE), 32'd0);

    // Overrun: two frames, no read in between.
    align();
    sb_q.push_back('{data: 8'h3C, fe: 1'b0, ovr: 1'b0});
    send_frame(8'h3C, 1'b1);
    check_frame("ovr_first");
    align();
    sb_q.push_back('{data: 8'hC3, fe: 1'b0, ovr: 1'b1});
    send_frame(8'hC3, 1'b1);
    check_frame("ovr_second");
    io_read(2'b00);
    chk("ovr_read_clears_rda", 32'(RDA), 32'd0);
    chk("ovr_read_clears_ovr", 32'(OVR), 32'd0);

    // Read in the exact load cycle while RDA is already set.
    align();
    sb_q.push_back('{data: 8'h11, fe: 1'b0, ovr: 1'b0});
    send_frame(8'h11, 1'b1);
    check_frame("pre_collide");
    align();
    sb_q.push_back('{data: 8'h55, fe: 1'b0, ovr: 1'b0});
    fork
      send_frame(8'h55, 1'b1);
      begin
        hold(off - 1);
        IORW = 1'b1;
        hold(1);
        IORW = 1'b0;
      end
    join
    check_frame("collide_55");

    // Reset during data bit 4 of a frame, then a clean frame.
    align();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        hold(BIT_CLKS * 5 + 32);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rx_data", 32'(RX_DATA), 32'h00);
        chk("midrst_rda", 32'(RDA), 32'd0);
        chk("midrst_fe", 32'(FE), 32'd0);
        chk("midrst_ovr", 32'(OVR), 32'd0);
        hold(3);
        rst = 1'b1;
      end
    join
    hold(100);
    chk("post_rst_no_load", 32'(RDA), 32'd0);
    align();
    sb_q.push_back('{data: 8'h81, fe: 1'b0, ovr: 1'b0});
    send_frame(8'h81, 1'b1);
    check_frame("post_rst_81");
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
